// File: rtl/npc_pkg.sv
// Shared constants and sizing helpers for the instruction prefetch block.
package npc_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Byte distance between consecutive instructions of width inst_w bits.
  function automatic int unsigned inst_bytes(input int unsigned inst_w);
    return inst_w / 8;
  endfunction

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_buf.sv
// Instruction buffer: FIFO with synchronous write, combinational head read,
// and flush. Simultaneous push and pop are accepted while full.
module inst_buf
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULLC = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULLC);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + ONE;
      2'b01:   count_next = count_reg - ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PONE;
      count_reg <= count_next;
    end
  end

  // The upstream credit scheme must never push into a full buffer without a pop.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: credit-limited in-order fetch into a small buffer,
// with redirect flush and discard of responses already in flight.
module inst_prefetch
  import npc_pkg::*;
#(
  parameter int          ADDR_W   = 64,
  parameter int          INST_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int                CNT_W   = cnt_width(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(inst_bytes(INST_W));
  localparam logic [ADDR_W-1:0] PC0     = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]        fpc_reg, fpc_next;
  logic [ADDR_W-1:0]        rpc_reg, rpc_next;
  logic [CNT_W-1:0]         outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]         drop_cnt_reg, drop_cnt_next;
  logic                     hold_reg, hold_next;
  logic [CNT_W-1:0]         occupancy;
  logic                     buf_full, buf_empty;
  logic                     credit_ok, accept, resp_take, resp_drop, pop;
  logic [INST_W+ADDR_W-1:0] head;

  // Credits cover both buffered entries and responses still owed by memory.
  assign credit_ok = !buf_full &&
                     (({1'b0, occupancy} + {1'b0, outstanding_reg}) < DEPTH_C);

  assign mem_req_valid = !reset && (ce || hold_reg) && !redirect &&
                         (drop_cnt_reg == '0) && credit_ok;
  assign mem_req_addr  = fpc_reg;
  assign accept        = mem_req_valid && mem_req_ready;

  assign resp_take = mem_resp_valid && !redirect && (drop_cnt_reg == '0);
  assign resp_drop = mem_resp_valid && !redirect && (drop_cnt_reg != '0);

  assign inst_valid = !reset && !buf_empty && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign inst       = head[INST_W+ADDR_W-1:ADDR_W];
  assign inst_pc    = head[ADDR_W-1:0];

  always_comb begin
    fpc_next         = fpc_reg;
    rpc_next         = rpc_reg;
    hold_next        = hold_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (redirect) begin
      fpc_next         = redirect_pc;
      rpc_next         = redirect_pc;
      hold_next        = 1'b0;
      outstanding_next = '0;
      // Everything still owed by memory becomes junk; a response landing now is already junk.
      drop_cnt_next    = drop_cnt_reg + outstanding_reg - CNT_W'(mem_resp_valid);
    end else begin
      if (accept)    fpc_next      = fpc_reg + STEP;
      if (resp_take) rpc_next      = rpc_reg + STEP;
      if (resp_drop) drop_cnt_next = drop_cnt_reg - ONE;
      if (accept)             hold_next = 1'b0;
      else if (mem_req_valid) hold_next = 1'b1;
      case ({accept, resp_take})
        2'b10:   outstanding_next = outstanding_reg + ONE;
        2'b01:   outstanding_next = outstanding_reg - ONE;
        default: outstanding_next = outstanding_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc_reg         <= PC0;
      rpc_reg         <= PC0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      hold_reg        <= 1'b0;
    end else begin
      fpc_reg         <= fpc_next;
      rpc_reg         <= rpc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      hold_reg        <= hold_next;
    end
  end

  inst_buf #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_take),
    .push_data ({mem_resp_data, rpc_reg}),
    .pop       (pop),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (occupancy)
  );

endmodule
